// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and write-port priority resolve for regfile_mp
package regfile_pkg;
   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int MAX_WR       = 8;
   typedef logic [$clog2(NUM_REGS_DEF)-1:0] addr_t;
   typedef logic [DATA_W_DEF-1:0] data_t;
   // Highest-indexed asserted port wins; -1 when no port hits
   function automatic int wr_winner(input logic [MAX_WR-1:0] hit);
      wr_winner = -1;
      for (int i = 0; i < MAX_WR; i++)
         if (hit[i]) wr_winner = i;
   endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with reserve/writeback priority and per-port busy
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [NUM_WR*AW-1:0] wr_addr,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_addr,
   input  logic [NUM_RD-1:0]    rd_en,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_REGS-1:0]  pend_vec,
   output logic [NUM_RD-1:0]    busy
);
   logic [NUM_REGS-1:0] clr;
   logic [MAX_WR-1:0]   hit;
   always_comb begin
      clr = '0;
      hit = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         hit = '0;
         for (int i = 0; i < NUM_WR; i++)
            hit[i] = wr_en[i] && wr_addr[i*AW +: AW] == AW'(r);
         clr[r] = wr_winner(hit) >= 0;
      end
   end
   // A reservation outranks a same-cycle writeback: the new producer keeps it pending
   always_ff @(posedge clk or negedge rst)
      if (!rst) pend_vec <= '0;
      else
         for (int r = 0; r < NUM_REGS; r++)
            pend_vec[r] <= (rsv_en && rsv_addr == AW'(r) && !(ZERO_REG != 0 && r == 0))
                           || (pend_vec[r] && !clr[r]);
   for (genvar j = 0; j < NUM_RD; j++) begin : g_busy
      logic [AW-1:0] ra;
      assign ra = rd_addr[j*AW +: AW];
      assign busy[j] = rst && rd_en[j] && !(ZERO_REG != 0 && ra == '0) && pend_vec[ra]
                       && !(BYPASS != 0 && clr[ra]);
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with optional write bypass
// and a per-register pending scoreboard
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [NUM_REGS-1:0]      pend_vec
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   // Ascending port order makes the highest-indexed write win on conflicts
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      else
         for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i] && !(ZERO_REG != 0 && wr_addr[i*AW +: AW] == '0))
               regs[wr_addr[i*AW +: AW]] <= wr_data[i*DATA_W +: DATA_W];
   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [MAX_WR-1:0] hit;
      int                w;
      int                ws;
      assign ra = rd_addr[j*AW +: AW];
      always_comb begin
         hit = '0;
         for (int i = 0; i < NUM_WR; i++)
            hit[i] = wr_en[i] && wr_addr[i*AW +: AW] == ra;
      end
      assign w  = wr_winner(hit);
      assign ws = w < 0 ? 0 : w;
      assign rd_data[j*DATA_W +: DATA_W] =
         (!rst || !rd_en[j] || (ZERO_REG != 0 && ra == '0)) ? '0 :
         (BYPASS != 0 && w >= 0) ? wr_data[ws*DATA_W +: DATA_W] : regs[ra];
   end
   regfile_scoreboard #(
      .NUM_REGS(NUM_REGS),
      .NUM_RD  (NUM_RD),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .pend_vec(pend_vec),
      .busy    (rd_busy)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of a bypassing and a non-bypassing
// regfile_mp against an array-based reference model
module tb_regfile_mp;
   logic        clk = 0;
   logic        rst = 0;
   logic [1:0]  wr_en = '0;
   logic [9:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        rsv_en = 0;
   logic [4:0]  rsv_addr = '0;
   logic [1:0]  rd_en = '0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic [31:0] pend_b, pend_n;
   logic [31:0] mem [32];
   logic [31:0] pend;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_mp #(.NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_b), .rd_busy(rd_busy_b), .pend_vec(pend_b));
   regfile_mp #(.NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_n), .rd_busy(rd_busy_n), .pend_vec(pend_n));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) mem[r] = '0;
      pend = '0;
   endtask

   task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic re_v, input logic [4:0] ra_v,
                        input logic [1:0] rde, input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
      rsv_en = re_v; rsv_addr = ra_v; rd_en = rde; rd_addr = {ra1, ra0};
   endtask

   // Compare all outputs against the model, then advance one clock and apply the cycle's effects
   task automatic step();
      logic [63:0] eb, en;
      logic [1:0]  bb, bn;
      logic [31:0] wd;
      logic        hit;
      int          a;
      #1;
      eb = '0; en = '0; bb = '0; bn = '0;
      for (int j = 0; j < 2; j++) begin
         a = int'(rd_addr[j*5 +: 5]);
         hit = 0; wd = '0;
         for (int i = 0; i < 2; i++)
            if (wr_en[i] && int'(wr_addr[i*5 +: 5]) == a) begin hit = 1; wd = wr_data[i*32 +: 32]; end
         if (rst && rd_en[j] && a != 0) begin
            eb[j*32 +: 32] = hit ? wd : mem[a];
            en[j*32 +: 32] = mem[a];
            bb[j] = pend[a] && !hit;
            bn[j] = pend[a];
         end
      end
      check("rd_data_byp", rd_data_b, eb);
      check("rd_data_nob", rd_data_n, en);
      check("rd_busy_byp", {62'b0, rd_busy_b}, {62'b0, bb});
      check("rd_busy_nob", {62'b0, rd_busy_n}, {62'b0, bn});
      check("pend_byp", {32'b0, pend_b}, {32'b0, pend});
      check("pend_nob", {32'b0, pend_n}, {32'b0, pend});
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 2; i++)
            if (wr_en[i]) begin
               pend[wr_addr[i*5 +: 5]] = 1'b0;
               if (wr_addr[i*5 +: 5] != 0) mem[wr_addr[i*5 +: 5]] = wr_data[i*32 +: 32];
            end
         if (rsv_en && rsv_addr != 0) pend[rsv_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   function automatic logic [4:0] raddr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
   endfunction

   initial begin
      model_reset();
      @(negedge clk);
      // write and reserve during reset must be ignored
      drive(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 0, 1, 5'd5, 2'b01, 5'd5, 5'd0);
      step();
      rst = 1;
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'd5, 5'd5);
      #1 check("t1_r5_after_reset", {32'b0, rd_data_b[31:0]}, 64'h0);
      step();
      // write/read latency
      drive(2'b01, 5'd3, 5'd0, 32'h1234_5678, 0, 0, 0, 2'b11, 5'd3, 5'd3);
      #1 check("t2_nob_same_cycle", {32'b0, rd_data_n[31:0]}, 64'h0);
      check("t2_byp_same_cycle", {32'b0, rd_data_b[31:0]}, 64'h1234_5678);
      step();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'd3, 5'd3);
      #1 check("t2_nob_next_cycle", {32'b0, rd_data_n[63:32]}, 64'h1234_5678);
      step();
      // zero register
      drive(2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 0, 1, 5'd0, 2'b11, 5'd0, 5'd0);
      #1 check("t3_r0_data", rd_data_b, 64'h0);
      step();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 5'd0);
      #1 check("t3_r0_pend", {63'b0, pend_b[0]}, 64'h0);
      step();
      // write-write conflict
      drive(2'b11, 5'd7, 5'd7, 32'hAAAA_AAAA, 32'h5555_5555, 0, 0, 2'b11, 5'd7, 5'd7);
      #1 check("t4_conflict_byp", rd_data_b, 64'h5555_5555_5555_5555);
      step();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'd7, 5'd7);
      #1 check("t4_conflict_next", rd_data_n, 64'h5555_5555_5555_5555);
      step();
      // scoreboard
      drive(2'b00, 0, 0, 0, 0, 1, 5'd9, 2'b00, 0, 0);
      step();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'd9, 5'd9);
      #1 check("t5_pend9_set", {63'b0, pend_b[9]}, 64'h1);
      check("t5_busy9", {62'b0, rd_busy_b}, 64'h3);
      step();
      step();
      drive(2'b01, 5'd9, 5'd0, 32'h42, 0, 0, 0, 2'b01, 5'd9, 5'd0);
      #1 check("t5_busy9_clear_byp", {62'b0, rd_busy_b}, 64'h0);
      check("t5_busy9_nob", {62'b0, rd_busy_n}, 64'h1);
      step();
      drive(2'b01, 5'd9, 5'd0, 32'h99, 0, 1, 5'd9, 2'b00, 0, 0);
      #1 check("t5_pend9_cleared", {63'b0, pend_b[9]}, 64'h0);
      step();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 5'd9, 5'd0);
      #1 check("t5_pend9_kept", {63'b0, pend_b[9]}, 64'h1);
      check("t5_r9_data", {32'b0, rd_data_n[31:0]}, 64'h99);
      step();
      // asynchronous reset mid-operation
      drive(2'b00, 0, 0, 0, 0, 1, 5'd4, 2'b00, 0, 0);
      step();
      drive(2'b01, 5'd4, 5'd0, 32'h7777, 0, 0, 0, 2'b01, 5'd4, 5'd0);
      #2 rst = 0;
      #1 check("t6_pend_async_clear", {32'b0, pend_b}, 64'h0);
      check("t6_rd_during_reset", rd_data_b, 64'h0);
      model_reset();
      step();
      rst = 1;
      drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'd4, 5'd4);
      #1 check("t6_r4_not_stored", rd_data_n, 64'h0);
      step();
      // randomized traffic with occasional reset pulses
      for (int n = 0; n < 400; n++) begin
         drive(2'($urandom), raddr(), raddr(), $urandom, $urandom,
               $urandom_range(0, 2) == 0, raddr(), 2'($urandom), raddr(), raddr());
         if ($urandom_range(0, 99) == 0) begin
            #2 rst = 0;
            model_reset();
            step();
            rst = 1;
         end else step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the core's 2R/1W register file.
- Adds configurable width, depth and read/write port counts, an optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit.
- The pending bit lets issue logic stall on operands whose producing write has not yet retired.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; must be a power of two, at least 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports.
- ZERO_REG, 1, if 1 then register 0 is hardwired to zero and never pending.
- BYPASS, 1, if 1 then a same-cycle write is forwarded to matching reads.
- Derived localparam AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  packed write addresses; port i is at [i*AW +: AW].
- wr_data  in  NUM_WR*DATA_W  packed write data.
- rsv_en  in  1  reserve request: mark rsv_addr as pending.
- rsv_addr  in  AW  register to reserve.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  packed read addresses.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  port j's register is pending after this cycle's updates.
- pend_vec  out  NUM_REGS  raw pending bits, registered; for debug and the stall unit.

Behaviour:
- Reset (rst low, asynchronous): all registers clear to 0; all pending bits clear to 0.
  - During reset: rd_data = 0, rd_busy = 0, pend_vec = 0.
  - Writes and reservations are ignored while rst is low.
  - Reset asserted mid-operation discards in-flight writes in that cycle.
- Writes: on posedge clk, for each port i with wr_en[i]=1, regs[wr_addr_i] <= wr_data_i.
  - Write latency is 1 cycle; without bypass, the data is readable the following cycle.
- Register 0 (ZERO_REG=1):
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 regardless of bypass.
  - Reservations of address 0 are ignored; rd_busy is never set for address 0.
- Write-write conflict: two or more enabled write ports with the same address in one cycle -> the highest-indexed port wins, for both storage and bypass.
- Reads (combinational):
  - rd_en[j]=0 -> rd_data_j = 0 and rd_busy[j] = 0.
  - rd_en[j]=1, BYPASS=1, address matches an enabled write this cycle -> rd_data_j = the winning write data; otherwise rd_data_j = the stored value.
  - BYPASS=0 -> always the stored value (old data on a same-cycle match).
- Pending bits, per register r, evaluated at posedge clk:
  - set if rsv_en and rsv_addr==r;
  - else cleared if any enabled write targets r;
  - else held.
  - A reservation and a write to the same register in the same cycle -> the register stays pending (new producer wins). The write data is still stored.
  - Reserving an already-pending register keeps it pending; there is no error and no counting.
- rd_busy[j] = pend[rd_addr_j] with this cycle's writeback clear applied. A register written this cycle reads not-busy when BYPASS=1; with BYPASS=0 rd_busy reflects registered pend only.
- No X propagation: all read paths are fully defined for any address within NUM_REGS.

Decomposition:
- Package regfile_pkg holds:
  - the default DATA_W and NUM_REGS constants;
  - the addr_t and data_t typedefs for the default configuration;
  - the function wr_winner(), a priority resolve across write ports, shared with the scoreboard.
- One sub-module: regfile_scoreboard.
  - Holds the NUM_REGS pending flops with set/clear/priority logic.
  - Outputs pend_vec and per-port busy.
- The storage array and bypass muxes stay in the top level.

Test Plan:
1. Reset then read: assert rst low, write 32'hDEAD_BEEF to r5 during reset, release; read r5 -> 0, pend_vec = 0.
2. Write/read latency (BYPASS=0): write r3 = 32'h1234_5678 at cycle N. A read of r3 at cycle N returns the old value 0; at cycle N+1 it returns 32'h1234_5678. Repeat with BYPASS=1: cycle N returns 32'h1234_5678.
3. Zero register: write r0 = 32'hFFFF_FFFF and reserve r0. A read of r0 on both ports returns 0; rd_busy = 0; pend_vec[0] = 0.
4. Write conflict (NUM_WR=2): port0 writes r7 = 32'hAAAA_AAAA and port1 writes r7 = 32'h5555_5555 in the same cycle. The bypass read and the next-cycle read both return 32'h5555_5555.
5. Scoreboard:
   - reserve r9 at cycle N -> pend_vec[9] = 1 at N+1 and rd_busy = 1 for reads of r9;
   - write r9 = 32'h42 at N+3 -> rd_busy = 0 at N+3 (BYPASS=1) and pend_vec[9] = 0 at N+4;
   - reserve and write r9 in the same cycle -> pend_vec[9] stays 1 and r9 = the written data.
6. Reset mid-operation: with r4 pending and a write to r4 in flight, pulse rst low asynchronously between edges. pend_vec clears immediately, r4 = 0, and the in-flight write is not stored.
